// File: rtl/dmem_responder.sv
// Data-port memory responder: one request at a time, WAIT_CYCLES wait states, byte-masked stores.
// Optional macro DMEM_STATS_EN adds rd_count/wr_count completion counters.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        req,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int         DEPTH     = 32'd1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (ADDR_WIDTH + 2)) != 32'd0);
  endfunction

  state_e                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [3:0]            req_we_q, req_we_d;
  logic [31:0]           req_addr_q, req_addr_d;
  logic [31:0]           req_wdata_q, req_wdata_d;
  logic                  ready_q, ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  access_s;
  logic                  fault_s;
  logic [3:0]            acc_we_s;
  logic [31:0]           acc_addr_s;
  logic [31:0]           acc_wdata_s;
  logic [ADDR_WIDTH-1:0] mem_idx_s;
  logic [3:0]            mem_wen_s;
  logic [31:0]           mem [DEPTH];

  // With zero wait states the access happens on the acceptance edge, so it must use the live inputs.
  assign acc_we_s    = (state_q == ST_IDLE) ? we    : req_we_q;
  assign acc_addr_s  = (state_q == ST_IDLE) ? addr  : req_addr_q;
  assign acc_wdata_s = (state_q == ST_IDLE) ? wdata : req_wdata_q;
  assign fault_s     = addr_fault(acc_addr_s);
  assign mem_idx_s   = acc_addr_s[ADDR_WIDTH+1:2];

  // Next-state, request capture and response generation.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    ready_d      = 1'b0;
    resp_valid_d = 1'b0;
    err_d        = 1'b0;
    rdata_d      = 32'd0;
    access_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          req_we_d    = we;
          req_addr_d  = addr;
          req_wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d  = ST_RESP;
            access_s = 1'b1;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d  = ST_RESP;
          access_s = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
    if (access_s) begin
      resp_valid_d = 1'b1;
      err_d        = fault_s;
      if (!fault_s && acc_we_s == 4'b0000) begin
        rdata_d = mem[mem_idx_s];
      end else begin
        rdata_d = 32'd0;
      end
    end else begin
      resp_valid_d = 1'b0;
    end
    // Reset on the access edge wins, so the store is dropped.
    mem_wen_s = (access_s && !fault_s && !rst) ? acc_we_s : 4'b0000;
  end

  // Controller state and registered outputs.
  always_ff @(posedge clka) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 4'd0;
      req_we_q     <= 4'd0;
      req_addr_q   <= 32'd0;
      req_wdata_q  <= 32'd0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  // Byte-masked array write; contents survive reset.
  always_ff @(posedge clka) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_wen_s[b]) begin
        mem[mem_idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
      end
    end
  end

  assign ready      = ready_q;
  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign err        = err_q;

`ifdef DMEM_STATS_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  // Count completed non-faulting loads and stores.
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (access_s && !fault_s) begin
      if (acc_we_s == 4'b0000) begin
        rd_count_d = rd_count_q + 32'd1;
      end else begin
        wr_count_d = wr_count_q + 32'd1;
      end
    end else begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clka) begin
    if (rst) begin
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 0, 1, 3) checked every cycle
// against an edge-counting reference model, plus directed literal checks.
`timescale 1ns/1ps
module tb_dmem_responder;
  localparam int NI = 3;

  function automatic int wc_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  logic        clka = 1'b0;
  logic        rst [NI];
  logic        req [NI];
  logic [3:0]  we_i [NI];
  logic [31:0] addr_i [NI];
  logic [31:0] wdata_i [NI];
  logic        ready [NI];
  logic        resp_valid [NI];
  logic [31:0] rdata [NI];
  logic        err [NI];
`ifdef DMEM_STATS_EN
  logic [31:0] rd_count [NI];
  logic [31:0] wr_count [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .ADDR_WIDTH (10),
      .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clka      (clka),
      .rst       (rst[g]),
      .req       (req[g]),
      .we        (we_i[g]),
      .addr      (addr_i[g]),
      .wdata     (wdata_i[g]),
      .ready     (ready[g]),
      .resp_valid(resp_valid[g]),
      .rdata     (rdata[g]),
      .err       (err[g])
`ifdef DMEM_STATS_EN
      ,
      .rd_count  (rd_count[g]),
      .wr_count  (wr_count[g])
`endif
    );
  end

  always #5 clka = ~clka;

  // Reference model state
  int          edge_cnt = 0;
  bit          m_init [NI];
  bit          m_ready [NI];
  bit          m_resp [NI];
  bit          m_zero [NI];
  bit          m_err [NI];
  logic [31:0] m_rdata [NI];
  logic [31:0] m_mask [NI];
  bit          m_pend [NI];
  int          p_edge [NI];
  logic [3:0]  p_we [NI];
  logic [31:0] p_addr [NI];
  logic [31:0] p_wdata [NI];
  int          m_free [NI];
  int          m_acc_edge [NI];
  logic [31:0] m_rd [NI];
  logic [31:0] m_wr [NI];
  logic [31:0] mmem [NI][1024];
  logic [3:0]  mknown [NI][1024];

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] obs_rdata [NI];
  logic        obs_err [NI];
  int          obs_edge [NI];
  int          obs_cnt [NI];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory access as the specification describes it, applied to the model array.
  task automatic model_access(input int k);
    int idx;
    idx = int'(p_addr[k][11:2]);
    m_resp[k] = 1'b1;
    if (p_addr[k][1:0] != 2'b00 || p_addr[k][31:12] != 20'd0) begin
      m_err[k] = 1'b1; m_rdata[k] = 32'd0; m_mask[k] = 32'hFFFF_FFFF;
    end else if (p_we[k] == 4'b0000) begin
      m_err[k] = 1'b0; m_rdata[k] = mmem[k][idx];
      for (int b = 0; b < 4; b++) m_mask[k][8*b +: 8] = {8{mknown[k][idx][b]}};
      m_rd[k] = m_rd[k] + 32'd1;
    end else begin
      m_err[k] = 1'b0; m_rdata[k] = 32'd0; m_mask[k] = 32'hFFFF_FFFF;
      for (int b = 0; b < 4; b++) begin
        if (p_we[k][b]) begin
          mmem[k][idx][8*b +: 8] = p_wdata[k][8*b +: 8];
          mknown[k][idx][b] = 1'b1;
        end
      end
      m_wr[k] = m_wr[k] + 32'd1;
    end
  endtask

  // Model: accept at edge n when ready, access at edge n+WC, ready again after edge n+WC+1.
  always @(posedge clka) begin
    edge_cnt = edge_cnt + 1;
    for (int k = 0; k < NI; k++) begin
      if (rst[k] === 1'b1) begin
        m_init[k] = 1'b1; m_zero[k] = 1'b1; m_pend[k] = 1'b0; m_ready[k] = 1'b1;
        m_resp[k] = 1'b0; m_err[k] = 1'b0; m_rdata[k] = 32'd0; m_mask[k] = 32'hFFFF_FFFF;
        m_rd[k] = 32'd0; m_wr[k] = 32'd0; m_free[k] = edge_cnt;
      end else if (m_init[k]) begin
        m_resp[k] = 1'b0;
        m_zero[k] = 1'b0;
        if (req[k] && m_ready[k]) begin
          m_pend[k] = 1'b1; p_edge[k] = edge_cnt + wc_of(k);
          p_we[k] = we_i[k]; p_addr[k] = addr_i[k]; p_wdata[k] = wdata_i[k];
          m_free[k] = edge_cnt + wc_of(k) + 1; m_acc_edge[k] = edge_cnt;
        end
        if (m_pend[k] && p_edge[k] == edge_cnt) begin
          m_pend[k] = 1'b0;
          model_access(k);
        end
        m_ready[k] = (edge_cnt >= m_free[k]);
      end
    end
  end

  // Compare DUT outputs with the model every cycle, away from the active edge.
  always @(negedge clka) begin
    for (int k = 0; k < NI; k++) begin
      if (m_init[k]) begin
        chk($sformatf("ready[%0d]", k), 32'(ready[k]), 32'(m_ready[k]));
        chk($sformatf("resp_valid[%0d]", k), 32'(resp_valid[k]), 32'(m_resp[k]));
        if (m_resp[k] || m_zero[k]) begin
          chk($sformatf("err[%0d]", k), 32'(err[k]), 32'(m_err[k]));
          chk($sformatf("rdata[%0d]", k), rdata[k] & m_mask[k], m_rdata[k] & m_mask[k]);
        end
`ifdef DMEM_STATS_EN
        chk($sformatf("rd_count[%0d]", k), rd_count[k], m_rd[k]);
        chk($sformatf("wr_count[%0d]", k), wr_count[k], m_wr[k]);
`endif
        if (resp_valid[k] === 1'b1) begin
          obs_rdata[k] = rdata[k]; obs_err[k] = err[k];
          obs_edge[k] = edge_cnt; obs_cnt[k] = obs_cnt[k] + 1;
        end
      end
    end
  end

  task automatic do_req(input int k, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    int i;
    req[k] = 1'b1; we_i[k] = w; addr_i[k] = a; wdata_i[k] = d;
    i = 0;
    do begin
      @(posedge clka); #1; i++;
    end while (m_acc_edge[k] != edge_cnt && i < 60);
    if (m_acc_edge[k] != edge_cnt) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout[%0d]: not accepted after %0d cycles, expected acceptance", k, i);
    end
    req[k] = 1'b0; we_i[k] = 4'($urandom); addr_i[k] = $urandom; wdata_i[k] = $urandom;
  endtask

  task automatic xact(input int k, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                      output int acc);
    int c0, i;
    c0 = obs_cnt[k];
    do_req(k, w, a, d);
    acc = edge_cnt;
    i = 0;
    while (obs_cnt[k] == c0 && i < 40) begin
      @(negedge clka); #1; i++;
    end
    if (obs_cnt[k] == c0) begin
      n_checks++; n_fail++;
      $display("FAIL resp_timeout[%0d]: no response seen, expected one", k);
    end
  endtask

  task automatic rand_traffic(input int k, input int n_req);
    logic [3:0]  w;
    logic [31:0] a;
    int          sel, j, wc;
    wc = wc_of(k);
    for (int n = 0; n < n_req; n++) begin
      w = ($urandom_range(0, 99) < 45) ? 4'd0 : 4'($urandom_range(1, 15));
      sel = int'($urandom_range(0, 19));
      case (sel)
        0: begin a = $urandom; a[12] = 1'b1; a[1:0] = 2'b00; end
        1: begin a = 32'($urandom_range(0, 63)); a[1:0] = 2'($urandom_range(1, 3)); end
        2: a = 32'h0000_0FFC;
        default: a = 32'($urandom_range(0, 15)) << 2;
      endcase
      do_req(k, w, a, $urandom);
      if ($urandom_range(0, 24) == 0) begin
        // Reset in a wait state (store dropped) or in the response cycle (store kept).
        j = (wc >= 2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, wc - 1)) : wc + 1;
        repeat (j - 1) begin @(posedge clka); #1; end
        rst[k] = 1'b1;
        @(posedge clka); #1;
        rst[k] = 1'b0;
      end else begin
        repeat ($urandom_range(0, 2)) begin @(posedge clka); #1; end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, c0;
    int e [6];
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we_i[k] = 4'd0; addr_i[k] = 32'd0; wdata_i[k] = 32'd0;
      m_acc_edge[k] = -1; obs_cnt[k] = 0; obs_edge[k] = 0; m_init[k] = 1'b0;
      for (int i = 0; i < 1024; i++) mknown[k][i] = 4'd0;
    end
    repeat (2) @(posedge clka);
    #1;
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    chk("reset_ready", 32'(ready[1]), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid[1]), 32'd0);
    chk("reset_rdata", rdata[1], 32'd0);
    chk("reset_err", 32'(err[1]), 32'd0);

    // WAIT_CYCLES=1 instance: store/load, byte merge, faults
    xact(1, 4'hF, 32'h10, 32'hDEAD_BEEF, acc);
    chk("store_latency", 32'(obs_edge[1] - acc + 1), 32'd2);
    chk("store_err", 32'(obs_err[1]), 32'd0);
    xact(1, 4'h0, 32'h10, 32'h0, acc);
    chk("load_latency", 32'(obs_edge[1] - acc + 1), 32'd2);
    chk("load_rdata", obs_rdata[1], 32'hDEAD_BEEF);
    chk("load_err", 32'(obs_err[1]), 32'd0);
    xact(1, 4'hF, 32'h20, 32'h1122_3344, acc);
    xact(1, 4'h5, 32'h20, 32'hAABB_CCDD, acc);
    xact(1, 4'h0, 32'h20, 32'h0, acc);
    chk("merge_rdata", obs_rdata[1], 32'h11BB_33DD);
    chk("merge_model", m_rdata[1], 32'h11BB_33DD);
    xact(1, 4'h0, 32'h22, 32'h0, acc);
    chk("misalign_err", 32'(obs_err[1]), 32'd1);
    chk("misalign_rdata", obs_rdata[1], 32'd0);
    xact(1, 4'hF, 32'h0, 32'hCAFE_F00D, acc);
    xact(1, 4'hF, 32'h0000_1000, 32'h1234_5678, acc);
    chk("range_err", 32'(obs_err[1]), 32'd1);
    xact(1, 4'h0, 32'h0, 32'h0, acc);
    chk("range_no_alias", obs_rdata[1], 32'hCAFE_F00D);

    // Reset and request on the same edge: not accepted
    c0 = obs_cnt[1];
    req[1] = 1'b1; we_i[1] = 4'hF; addr_i[1] = 32'h10; wdata_i[1] = 32'h0;
    rst[1] = 1'b1;
    @(posedge clka); #1;
    rst[1] = 1'b0; req[1] = 1'b0;
    chk("rst_req_ready", 32'(ready[1]), 32'd1);
    repeat (4) @(posedge clka);
    #1;
    chk("rst_req_no_resp", 32'(obs_cnt[1] - c0), 32'd0);

    // WAIT_CYCLES=3 instance: reset during second wait cycle discards the store
    xact(2, 4'hF, 32'h40, 32'h0102_0304, acc);
    c0 = obs_cnt[2];
    do_req(2, 4'hF, 32'h40, 32'h5A5A_5A5A);
    @(posedge clka); #1;
    rst[2] = 1'b1;
    @(posedge clka); #1;
    rst[2] = 1'b0;
    chk("midwait_ready", 32'(ready[2]), 32'd1);
    repeat (6) @(posedge clka);
    #1;
    chk("midwait_no_resp", 32'(obs_cnt[2] - c0), 32'd0);
    xact(2, 4'h0, 32'h40, 32'h0, acc);
    chk("midwait_prior", obs_rdata[2], 32'h0102_0304);

    // WAIT_CYCLES=0 instance: back-to-back requests
    do_req(0, 4'hF, 32'h80, 32'h0BAD_F00D); e[0] = edge_cnt;
    do_req(0, 4'hF, 32'h84, 32'h600D_CAFE); e[1] = edge_cnt;
    do_req(0, 4'h0, 32'h80, 32'h0);         e[2] = edge_cnt;
    do_req(0, 4'h0, 32'h84, 32'h0);         e[3] = edge_cnt;
    do_req(0, 4'h0, 32'h80, 32'h0);         e[4] = edge_cnt;
    do_req(0, 4'h0, 32'h81, 32'h0);         e[5] = edge_cnt;
    for (int i = 1; i < 6; i++) chk($sformatf("b2b_spacing%0d", i), 32'(e[i] - e[i-1]), 32'd2);
    repeat (3) @(posedge clka);
    #1;
    chk("b2b_last_err", 32'(obs_err[0]), 32'd1);
`ifdef DMEM_STATS_EN
    chk("stats_rd", rd_count[0], 32'd3);
    chk("stats_wr", wr_count[0], 32'd2);
`endif

    fork
      rand_traffic(0, 150);
      rand_traffic(1, 150);
      rand_traffic(2, 150);
    join
    repeat (10) @(posedge clka);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
